// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
// Holds the FSM state encoding, frame geometry, counter width and command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } ps2_state_e;

  typedef enum logic [7:0] {
    CMD_SET_LED = 8'hED,
    CMD_ENABLE  = 8'hF4,
    CMD_RESEND  = 8'hFE,
    CMD_RESET   = 8'hFF
  } ps2_cmd_e;

  localparam int FRAME_BITS = 11;
  localparam int CNT_W      = 18;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser and falling-edge detector for the PS/2 clock and data pads.
// Ports: CLK/nRESET, raw pad inputs, synced levels and one-cycle fall pulses.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic PS2_CLK_IN,
  input  logic PS2_DATA_IN,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall,
  output logic data_fall
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   clk_prev;
  logic                   data_prev;

  // Idle bus is pulled high, so reset to 1 to avoid a false fall.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      clk_q     <= '1;
      data_q    <= '1;
      clk_prev  <= 1'b1;
      data_prev <= 1'b1;
    end else begin
      clk_q     <= {clk_q[SYNC_STAGES-2:0], PS2_CLK_IN};
      data_q    <= {data_q[SYNC_STAGES-2:0], PS2_DATA_IN};
      clk_prev  <= clk_q[SYNC_STAGES-1];
      data_prev <= data_q[SYNC_STAGES-1];
    end
  end

  assign clk_s     = clk_q[SYNC_STAGES-1];
  assign data_s    = data_q[SYNC_STAGES-1];
  assign clk_fall  = clk_prev & ~clk_s;
  assign data_fall = data_prev & ~data_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ACK.
// Ports: TX_* byte handshake and status, BUSY, pad inputs, open-drain OE outputs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1600,
  parameter int TIMEOUT_CYCLES = 240000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERROR,
  output logic       BUSY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_SHIFT =
    BIT_W'(FRAME_BITS - 2);

  ps2_state_e            state;
  logic [FRAME_BITS-2:0] shift;
  logic [BIT_W-1:0]      bitcnt;
  logic [CNT_W-1:0]      cnt;

  logic clk_s;
  logic data_s;
  logic clk_fall;
  logic data_fall_unused;
  logic timing;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .PS2_CLK_IN (PS2_CLK_IN),
    .PS2_DATA_IN(PS2_DATA_IN),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fall   (clk_fall),
    .data_fall  (data_fall_unused)
  );

  // Timeout window: from RTS entry until the bus returns idle.
  assign timing = (state != S_IDLE) && (state != S_INHIBIT);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state       <= S_IDLE;
      shift       <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      TX_READY    <= 1'b1;
      TX_DONE     <= 1'b0;
      TX_ERROR    <= 1'b0;
      BUSY        <= 1'b0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
    end else begin
      TX_DONE  <= 1'b0;
      TX_ERROR <= 1'b0;
      if (timing && cnt == TMO_LAST) begin
        PS2_CLK_OE  <= 1'b0;
        PS2_DATA_OE <= 1'b0;
        TX_ERROR    <= 1'b1;
        BUSY        <= 1'b0;
        state       <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            TX_READY <= 1'b1;
            // READY is still low in a DONE/ERROR cycle, so
            // a request then is dropped rather than queued.
            if (TX_VALID && TX_READY) begin
              shift      <= {1'b1, odd_parity(TX_DATA), TX_DATA};
              cnt        <= '0;
              PS2_CLK_OE <= 1'b1;
              TX_READY   <= 1'b0;
              BUSY       <= 1'b1;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (!PS2_DATA_OE) begin
              cnt <= cnt + 1'b1;
              if (cnt == INH_LAST) PS2_DATA_OE <= 1'b1;
            end else begin
              // Start bit is on the wire; release the clock.
              PS2_CLK_OE <= 1'b0;
              cnt        <= '0;
              bitcnt     <= '0;
              state      <= S_RTS;
            end
          end
          S_RTS: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              PS2_DATA_OE <= ~shift[0];
              shift       <= {1'b0, shift[FRAME_BITS-2:1]};
              bitcnt      <= BIT_W'(1);
              state       <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              PS2_DATA_OE <= ~shift[0];
              shift       <= {1'b0, shift[FRAME_BITS-2:1]};
              bitcnt      <= bitcnt + 1'b1;
              // This fall puts the stop bit (a release) out.
              if (bitcnt == LAST_SHIFT) state <= S_ACK;
            end
          end
          S_ACK: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              if (!data_s) begin
                state <= S_WAIT_IDLE;
              end else begin
                TX_ERROR <= 1'b1;
                BUSY     <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            cnt <= cnt + 1'b1;
            if (clk_s && data_s) begin
              TX_DONE <= 1'b1;
              BUSY    <= 1'b0;
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
